// File: rtl/uart_seq_pkg.sv
// Shared types and helpers for the UART command-script sequencer.
package uart_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_WAIT_DLY  = 2'd1,
    SEQ_SEND      = 2'd2,
    SEQ_WAIT_DONE = 2'd3
  } seq_state_t;

  // Address width that stays at least one bit wide for tiny depths.
  function automatic int seq_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Largest programmable per-entry delay for the default delay width.
  localparam int              DEF_DLY_W = 16;
  localparam longint unsigned MAX_DLY   = (64'd1 << DEF_DLY_W) - 64'd1;

endpackage

// File: rtl/seq_script_mem.sv
// Script storage: DEPTH entries of {delay, command byte}, one write port,
// two asynchronous read ports (data at the playing entry, delay at the next one).
module seq_script_mem
  import uart_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int DLY_W  = 16
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [seq_addr_w(DEPTH)-1:0] i_waddr,
  input  logic [DLY_W-1:0]             i_wdly,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic [seq_addr_w(DEPTH)-1:0] i_data_addr,
  input  logic [seq_addr_w(DEPTH)-1:0] i_dly_addr,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic [DLY_W-1:0]             o_rd_dly
);

  logic [DLY_W-1:0]  r_dly  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  // Capture a script entry on a qualified write strobe.
  // NOTE: the array has no reset; it is plain storage that software always
  // writes before use, and leaving it unreset keeps it as simple registers.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_dly[i_waddr]  <= i_wdly;
      r_data[i_waddr] <= i_wdata;
    end
  end

  assign o_rd_data = r_data[i_data_addr];
  assign o_rd_dly  = r_dly[i_dly_addr];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Plays a stored {delay, byte} script into UART_tx, with loop mode and abort.
module uart_cmd_sequencer
  import uart_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int DLY_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [seq_addr_w(DEPTH)-1:0] wr_addr,
  input  logic [DLY_W-1:0]             wr_dly,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [seq_addr_w(DEPTH):0]   len,
  input  logic                         loop_mode,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         tx_done,
  output logic                         trmt,
  output logic [DATA_W-1:0]            tx_data,
  output logic                         busy,
  output logic                         done,
  output logic [seq_addr_w(DEPTH)-1:0] idx
);

  localparam int          AW      = seq_addr_w(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  seq_state_t        r_state, w_state_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [DLY_W-1:0]  r_cnt, w_cnt_nxt;
  logic [AW:0]       r_len, w_len_nxt;
  logic              r_loop, w_loop_nxt;
  logic              r_trmt, w_trmt_nxt;
  logic              r_done, w_done_nxt;
  logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;

  logic              w_last;
  logic [AW-1:0]     w_dly_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DLY_W-1:0]  w_rd_dly;

  // Writes are only accepted while idle so a running script never changes.
  seq_script_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .DLY_W  (DLY_W)
  ) u_mem (
    .clk         (clk),
    .i_we        (wr_en && (r_state == SEQ_IDLE)),
    .i_waddr     (wr_addr),
    .i_wdly      (wr_dly),
    .i_wdata     (wr_data),
    .i_data_addr (r_idx),
    .i_dly_addr  (w_dly_addr),
    .o_rd_data   (w_rd_data),
    .o_rd_dly    (w_rd_dly)
  );

  assign w_last = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));

  // The delay port looks at the entry that will play next: entry 0 on start
  // or wrap, otherwise the one after the byte just finished.
  assign w_dly_addr = ((r_state == SEQ_WAIT_DONE) && !w_last) ? (r_idx + AW'(1)) : '0;

  // Next-state and next-output decode; abort overrides everything else.
  // NOTE: every target gets a default first, so no path leaves a variable
  // unassigned and no latch is inferred; trmt/done default low to make pulses.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_len_nxt     = r_len;
    w_loop_nxt    = r_loop;
    w_trmt_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_tx_data_nxt = r_tx_data;
    if (abort) begin
      w_state_nxt = SEQ_IDLE;
    end else begin
      unique case (r_state)
        SEQ_IDLE: begin
          if (start) begin
            if (len == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_len_nxt   = (len > LEN_MAX) ? LEN_MAX : len;
              w_loop_nxt  = loop_mode;
              w_idx_nxt   = '0;
              w_cnt_nxt   = w_rd_dly;
              w_state_nxt = SEQ_WAIT_DLY;
            end
          end
        end
        SEQ_WAIT_DLY: begin
          if (r_cnt == '0) w_state_nxt = SEQ_SEND;
          else             w_cnt_nxt   = r_cnt - DLY_W'(1);
        end
        SEQ_SEND: begin
          w_trmt_nxt    = 1'b1;
          w_tx_data_nxt = w_rd_data;
          w_state_nxt   = SEQ_WAIT_DONE;
        end
        SEQ_WAIT_DONE: begin
          if (tx_done) begin
            if (w_last && !r_loop) begin
              w_state_nxt = SEQ_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt   = w_last ? '0 : (r_idx + AW'(1));
              w_cnt_nxt   = w_rd_dly;
              w_state_nxt = SEQ_WAIT_DLY;
            end
          end
        end
        default: w_state_nxt = SEQ_IDLE;
      endcase
    end
  end

  // State and registered outputs; trmt comes straight from a flop so it is glitch-free.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEQ_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_loop    <= 1'b0;
      r_trmt    <= 1'b0;
      r_done    <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_len     <= w_len_nxt;
      r_loop    <= w_loop_nxt;
      r_trmt    <= w_trmt_nxt;
      r_done    <= w_done_nxt;
      r_tx_data <= w_tx_data_nxt;
    end
  end

  assign trmt    = r_trmt;
  assign tx_data = r_tx_data;
  assign busy    = (r_state != SEQ_IDLE);
  assign done    = r_done;
  assign idx     = r_idx;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomised bench for uart_cmd_sequencer with a UART_tx stub and a
// transaction-level model that predicts when each byte and done pulse appear.
module tb_uart_cmd_sequencer;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int DLY_W  = 16;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DLY_W-1:0]  wr_dly = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [AW:0]       len = '0;
  logic              loop_mode = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              tx_done = 1'b0;
  logic              trmt;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [AW-1:0]     idx;

  uart_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_dly(wr_dly),
    .wr_data(wr_data), .len(len), .loop_mode(loop_mode), .start(start),
    .abort(abort), .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data),
    .busy(busy), .done(done), .idx(idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference script contents and playback expectations.
  int unsigned       ref_dly [DEPTH];
  logic [DATA_W-1:0] ref_data[DEPTH];
  bit                m_busy = 0, m_loop = 0, m_waiting = 0;
  bit                exp_trmt = 0, exp_done = 0;
  int                m_len = 0, m_pos = 0, m_next_trmt = 0, m_trmt_edge = 0, m_lat = 2;
  int                m_start_edge = 0;
  logic [DATA_W-1:0] m_tx_data = '0;
  int                lat_max = 12;
  bit                noise = 0;

  int                obs_trmt = 0, obs_done = 0, done_cyc = 0;
  int                trmt_q[$];
  int                txdone_q[$];
  logic [DATA_W-1:0] byte_q[$];

  // Predict what the sequencer does at edge e given the inputs now driven.
  task automatic model(input int e);
    bit do_wr;
    do_wr = wr_en && !m_busy;
    exp_trmt = 0;
    exp_done = 0;
    if (abort) begin
      m_busy = 0;
      m_waiting = 0;
    end else if (!m_busy) begin
      if (start) begin
        if (len == 0) exp_done = 1;
        else begin
          m_busy = 1;
          m_len = (int'(len) > DEPTH) ? DEPTH : int'(len);
          m_loop = loop_mode;
          m_pos = 0;
          m_next_trmt = e + int'(ref_dly[0]) + 2;
          m_start_edge = e;
        end
      end
    end else if (m_waiting) begin
      if (tx_done) begin
        m_waiting = 0;
        if (m_pos == m_len - 1 && !m_loop) begin
          m_busy = 0;
          exp_done = 1;
        end else begin
          m_pos = (m_pos + 1) % m_len;
          m_next_trmt = e + int'(ref_dly[m_pos]) + 2;
        end
      end
    end else if (e == m_next_trmt) begin
      exp_trmt = 1;
      m_tx_data = ref_data[m_pos];
      m_waiting = 1;
      m_trmt_edge = e;
      m_lat = $urandom_range(2, lat_max);
    end
    if (do_wr) begin
      ref_dly[wr_addr]  = wr_dly;
      ref_data[wr_addr] = wr_data;
    end
  endtask

  // One clock: drive stub/noise inputs, predict, advance, compare outputs.
  task automatic step();
    int e;
    e = cyc + 1;
    tx_done = 1'b0;
    if (m_waiting && e == m_trmt_edge + m_lat) begin
      tx_done = 1'b1;
      txdone_q.push_back(e);
    end else if (!m_waiting && noise && $urandom_range(0, 7) == 0) begin
      tx_done = 1'b1;
    end
    if (noise && m_busy && !wr_en && $urandom_range(0, 5) == 0) begin
      wr_en = 1'b1;
      wr_addr = AW'($urandom);
      wr_dly = DLY_W'($urandom);
      wr_data = DATA_W'($urandom);
    end
    if (noise && m_busy && $urandom_range(0, 5) == 0) start = 1'b1;
    model(e);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("trmt", trmt, exp_trmt);
    check("done", done, exp_done);
    check("busy", busy, m_busy);
    check("idx", idx, m_pos);
    check("tx_data", tx_data, m_tx_data);
    if (trmt === 1'b1) begin
      obs_trmt++;
      trmt_q.push_back(cyc);
      byte_q.push_back(tx_data);
    end
    if (done === 1'b1) begin
      obs_done++;
      done_cyc = cyc;
    end
    start = 1'b0;
    abort = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic clear_obs();
    obs_trmt = 0;
    obs_done = 0;
    trmt_q.delete();
    txdone_q.delete();
    byte_q.delete();
  endtask

  task automatic write_entry(input int a, input int d, input logic [DATA_W-1:0] b);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_dly = DLY_W'(d);
    wr_data = b;
    step();
  endtask

  task automatic kick(input int n, input bit lp);
    len = (AW+1)'(n);
    loop_mode = lp;
    start = 1'b1;
    step();
  endtask

  task automatic run_idle(input int max);
    for (int i = 0; i < max && m_busy; i++) step();
    check("timeout_idle", busy, 1'b0);
  endtask

  task automatic run_sent(input int k, input int max);
    for (int i = 0; i < max && obs_trmt < k; i++) step();
    check("timeout_trmt", (obs_trmt >= k), 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trmt", trmt, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_idx", idx, 0);
    check("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;

    // Basic three-entry script.
    write_entry(0, 0, 8'h05);
    write_entry(1, 10, 8'h06);
    write_entry(2, 0, 8'h07);
    clear_obs();
    kick(3, 0);
    run_idle(200);
    repeat (3) step();
    check("s1_trmt_count", obs_trmt, 3);
    check("s1_done_count", obs_done, 1);
    check("s1_byte0", byte_q[0], 8'h05);
    check("s1_byte1", byte_q[1], 8'h06);
    check("s1_byte2", byte_q[2], 8'h07);
    check("s1_done_lat", done_cyc, txdone_q[2]);

    // Long first delay: exact latency checks.
    write_entry(0, 100, 8'h05);
    clear_obs();
    kick(3, 0);
    run_idle(400);
    check("s2_first_lat", trmt_q[0] - m_start_edge, 102);
    check("s2_second_lat", trmt_q[1] - txdone_q[0], 12);

    // Loop mode, abort after the fifth byte.
    write_entry(0, 3, 8'h05);
    write_entry(1, 1, 8'h06);
    clear_obs();
    kick(2, 1);
    run_sent(5, 400);
    abort = 1'b1;
    step();
    check("s3_abort_busy", busy, 1'b0);
    repeat (40) step();
    check("s3_trmt_count", obs_trmt, 5);
    check("s3_done_count", obs_done, 0);
    for (int i = 0; i < 5; i++) check("s3_byte", byte_q[i], (i % 2) ? 8'h06 : 8'h05);

    // Empty script.
    clear_obs();
    kick(0, 0);
    repeat (4) step();
    check("s4_done_count", obs_done, 1);
    check("s4_trmt_count", obs_trmt, 0);

    // Writes and starts while busy are ignored.
    write_entry(0, 0, 8'h05);
    write_entry(2, 0, 8'h07);
    clear_obs();
    kick(3, 0);
    wr_en = 1'b1; wr_addr = '0; wr_dly = '0; wr_data = 8'hAA; start = 1'b1;
    step();
    start = 1'b1;
    step();
    run_idle(200);
    check("s5_trmt_count", obs_trmt, 3);
    clear_obs();
    kick(3, 0);
    run_idle(200);
    check("s5_replay_byte0", byte_q[0], 8'h05);

    // Reset while waiting on tx_done, then replay from entry 0.
    lat_max = 30;
    clear_obs();
    kick(3, 0);
    run_sent(1, 100);
    step();
    rst_n = 1'b0;
    #1;
    check("s6_trmt", trmt, 1'b0);
    check("s6_busy", busy, 1'b0);
    check("s6_done", done, 1'b0);
    check("s6_idx", idx, 0);
    check("s6_tx_data", tx_data, 0);
    m_busy = 0; m_waiting = 0; m_pos = 0; m_tx_data = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    lat_max = 12;
    clear_obs();
    kick(3, 0);
    run_idle(200);
    check("s6_replay_byte0", byte_q[0], 8'h05);

    // Randomised scripts with noise, clamping, loops and aborts.
    noise = 1;
    for (int it = 0; it < 25; it++) begin
      int n;
      bit lp;
      for (int a = 0; a < DEPTH; a++)
        write_entry(a, $urandom_range(0, 6), DATA_W'($urandom));
      n = $urandom_range(0, 20);
      lp = ($urandom_range(0, 2) == 0);
      clear_obs();
      kick(n, lp);
      if (n == 0) begin
        repeat (3) step();
      end else if (lp || $urandom_range(0, 3) == 0) begin
        run_sent($urandom_range(1, 8), 600);
        repeat ($urandom_range(0, 6)) step();
        abort = 1'b1;
        step();
        repeat (5) step();
      end else begin
        run_idle(1200);
      end
      check("rnd_idle", busy, 1'b0);
    end
    noise = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Synthesizable, parametrised command-script player that drives UART_tx (trmt/tx_data/tx_done) with a stored sequence of {delay, command byte} entries.
- Replaces hand-coded send_cmd/cmd stimulus in Segway-level benches.
- Also usable on-board as a canned-command source feeding the Segway RX line through UART_tx.
- Adds programmable inter-command delay, loop mode and abort.

Parameters:
DEPTH, 16, number of script entries (power of 2, >=2)
DATA_W, 8, command byte width (must match UART_tx tx_data)
DLY_W, 16, width of per-entry delay field, in clk cycles

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset (synchronized global reset from rst_synch)
wr_en  in  1  script write strobe; honoured only in IDLE
wr_addr  in  $clog2(DEPTH)  entry index to write
wr_dly  in  DLY_W  delay field for entry
wr_data  in  DATA_W  command byte for entry
len  in  $clog2(DEPTH)+1  number of valid entries (0..DEPTH), sampled on start
loop_mode  in  1  1 = restart at entry 0 after last entry; sampled on start
start  in  1  begin playback; honoured only in IDLE
abort  in  1  stop playback; return to IDLE
tx_done  in  1  from UART_tx: byte finished
trmt  out  1  to UART_tx: one-cycle transmit strobe
tx_data  out  DATA_W  to UART_tx: command byte, registered
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a non-looping script completes
idx  out  $clog2(DEPTH)  index of entry currently being played

Behaviour:
- Reset values: trmt=0, tx_data=0, busy=0, done=0, idx=0, state=IDLE, delay counter=0, len/loop latches=0. Script memory is not reset.
- Script memory: DEPTH x (DLY_W+DATA_W) registers. A write happens on a clk edge with wr_en=1 and state=IDLE. wr_en is ignored when busy.
- States: IDLE, WAIT_DLY, SEND, WAIT_DONE.
- IDLE with start=1 and len>0: latch len and loop_mode, set idx=0, set cnt=dly[0], go to WAIT_DLY.
- IDLE with start=1 and len=0: pulse done the next cycle, stay IDLE, never assert trmt.
- WAIT_DLY: if cnt==0 go to SEND, otherwise decrement cnt.
- SEND: assert trmt for exactly one cycle with tx_data=data[idx] valid in the same cycle, then go to WAIT_DONE. tx_data holds its value until the next SEND.
- WAIT_DONE, waiting on tx_done:
  - If idx==len-1 and loop_mode=0: go to IDLE and pulse done for one cycle.
  - If idx==len-1 and loop_mode=1: set idx=0, load cnt=dly[0], go to WAIT_DLY.
  - Otherwise: idx++, load cnt=dly[idx+1], go to WAIT_DLY.
- Latency:
  - Start sampled at edge E: trmt is high in cycle E+dly[0]+2.
  - tx_done sampled at edge T: next trmt is high in cycle T+dly[next]+2.
- abort=1 in any state: go to IDLE on the next edge. trmt is forced 0 in that cycle and done is not pulsed. Abort has priority over start, tx_done and the counter. A byte already handed to UART_tx completes on the line; the sequencer ignores its later tx_done.
- start while busy is ignored. tx_done outside WAIT_DONE is ignored.
- Delay counter is DLY_W wide, so the maximum delay is 2^DLY_W-1. The counter never wraps below 0.
- Asynchronous reset mid-playback returns to reset values immediately. No trmt glitch: trmt is a flop output.
- len>DEPTH is clamped to DEPTH when latched.

Decomposition:
- Package uart_seq_pkg holds the state enum typedef (seq_state_t) and a function clog2-safe width helper; constants MAX_DLY derived from DLY_W.
- One sub-module is natural: seq_script_mem, the DEPTH-entry register file with a single write port and an asynchronous read port addressed by idx/idx+1.
- The FSM, counter and outputs stay in the top module.

Test Plan:
- Load 3 entries {dly=0,0x05},{dly=10,0x06},{dly=0,0x07}; len=3, loop=0, start -> UART_tx/Segway RX receives 05,06,07 in order; trmt high exactly 3 cycles total; done pulses once 1 cycle after third tx_done; busy=0 after.
- Same script with dly[0]=100 -> trmt rises exactly 102 cycles after start edge; second trmt exactly 12 cycles after first tx_done.
- loop_mode=1, len=2 {0x05,0x06} -> byte stream 05,06,05,06...; done never asserted; idx wraps 1->0; abort after 5th trmt -> busy=0 next cycle, no 6th trmt, no done.
- len=0 start -> done pulse next cycle, trmt stays 0, busy stays 0.
- wr_en to entry 0 (data 0xAA) while busy and start re-asserted mid-script -> entry 0 unchanged (still 0x05 on replay), playback order unaffected.
- RST_n asserted while in WAIT_DONE -> trmt/busy/done/idx/tx_data = 0 immediately; after release a fresh start replays from entry 0.
